// File: rtl/tilemap_scanner.sv
// tilemap_scanner
//
// Walks a COLS x ROWS tile map once per start request. For every cell it reads
// the tile index from the map RAM. It skips indices outside the tile ROM, and
// for every other cell it hands the tile's ROM base and screen origin to a
// downstream tile drawer, then waits for the drawer to finish.
//
// Optional feature: define TILEMAP_SKIP_BLANK_EN so that index 0 is treated
// as a blank cell and is skipped like an out-of-range index.
//
// Ports
//   clk            sole clock, rising edge
//   resetn         asynchronous, active-low reset
//   start          request one full-screen redraw (ignored while scanning)
//   map_address    tile-map RAM address, row*COLS+col
//   map_data       tile index, valid one cycle after map_address changes
//   drawer_active  busy flag of the downstream tile drawer
//   draw           one-cycle request to the tile drawer
//   tile_address   ROM byte base of the tile, index*192
//   x_pos, y_pos   tile origin in pixels, col*8 and row*8
//   busy           high from start acceptance until frame completion
//   done           one-cycle pulse at frame completion
//   timeout_err    sticky flag: the drawer did not acknowledge a draw
module tilemap_scanner #(
    parameter int COLS      = 20,
    parameter int ROWS      = 15,
    parameter int NUM_TILES = 21
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic [8:0]  map_address,
    input  logic [7:0]  map_data,
    input  logic        drawer_active,
    output logic        draw,
    output logic [11:0] tile_address,
    output logic [7:0]  x_pos,
    output logic [7:0]  y_pos,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] COL_LAST    = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);
    localparam logic [8:0]    TILE_LIMIT  = 9'(NUM_TILES);
    localparam logic [3:0]    ACK_LAST    = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_MAP,
        ISSUE,
        WAIT_ACK,
        WAIT_DRAW,
        NEXT,
        FINISH
    } state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [3:0]    ack_count;

    logic          skip_cell;
    logic          last_cell;
    logic [11:0]   tile_base;
    logic [7:0]    x_cell;
    logic [7:0]    y_cell;

`ifdef TILEMAP_SKIP_BLANK_EN
    assign skip_cell = ({1'b0, map_data} >= TILE_LIMIT) || (map_data == 8'd0);
`else
    assign skip_cell = ({1'b0, map_data} >= TILE_LIMIT);
`endif

    // index*192 as index*128 + index*64; the 12-bit result wraps for large
    // indices, but those are skipped and never reach the drawer.
    assign tile_base = {map_data[4:0], 7'b000_0000} + {map_data[5:0], 6'b00_0000};
    assign x_cell    = 8'({col, 3'b000});
    assign y_cell    = 8'({row, 3'b000});
    assign last_cell = (col == COL_LAST) && (row == ROW_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            ack_count    <= '0;
            map_address  <= '0;
            tile_address <= '0;
            x_pos        <= '0;
            y_pos        <= '0;
            draw         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            // draw and done are single-cycle pulses
            draw <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        col         <= '0;
                        row         <= '0;
                        map_address <= '0;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                        state       <= READ;
                    end
                end
                // map_address already holds row*COLS+col here; the RAM answers
                // in the following cycle.
                READ: state <= WAIT_MAP;
                WAIT_MAP: begin
                    tile_address <= tile_base;
                    x_pos        <= x_cell;
                    y_pos        <= y_cell;
                    if (skip_cell) begin
                        state <= NEXT;
                    end else begin
                        draw      <= 1'b1;
                        ack_count <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT_ACK;
                WAIT_ACK: begin
                    if (drawer_active) begin
                        state <= WAIT_DRAW;
                    end else if (ack_count == ACK_LAST) begin
                        // 16th cycle without acknowledge: give up on this cell
                        timeout_err <= 1'b1;
                        state       <= NEXT;
                    end else begin
                        ack_count <= ack_count + 4'd1;
                    end
                end
                WAIT_DRAW: begin
                    if (!drawer_active) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (last_cell) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        // cells are visited in raster order, so the map
                        // address is simply the running cell count
                        map_address <= map_address + 9'd1;
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                        state <= READ;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tilemap_scanner.sv
module tb_tilemap_scanner;

    localparam int COLS  = 20;
    localparam int ROWS  = 15;
    localparam int CELLS = COLS * ROWS;
    localparam int NT    = 21;
`ifdef TILEMAP_SKIP_BLANK_EN
    localparam bit SKIP_BLANK = 1'b1;
`else
    localparam bit SKIP_BLANK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [8:0]  map_address;
    logic [7:0]  map_data;
    logic        drawer_active;
    logic        draw;
    logic [11:0] tile_address;
    logic [7:0]  x_pos;
    logic [7:0]  y_pos;
    logic        busy;
    logic        done;
    logic        timeout_err;

    tilemap_scanner #(.COLS(COLS), .ROWS(ROWS), .NUM_TILES(NT)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .map_address   (map_address),
        .map_data      (map_data),
        .drawer_active (drawer_active),
        .draw          (draw),
        .tile_address  (tile_address),
        .x_pos         (x_pos),
        .y_pos         (y_pos),
        .busy          (busy),
        .done          (done),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    // Tile-map RAM: synchronous read, data one cycle after the address.
    logic [7:0] mem [0:CELLS-1];
    always @(posedge clk) begin
        if (int'(map_address) < CELLS) map_data <= mem[map_address];
        else                           map_data <= 8'hFF;
    end

    // Drawer model: goes active the cycle after draw, stays active dr_dur cycles.
    int dr_dur   = 1;
    bit dr_never = 1'b0;
    int dr_left;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drawer_active <= 1'b0;
            dr_left       <= 0;
        end else if (draw && !dr_never) begin
            drawer_active <= 1'b1;
            dr_left       <= dr_dur;
        end else if (dr_left > 1) begin
            dr_left <= dr_left - 1;
        end else begin
            drawer_active <= 1'b0;
            dr_left       <= 0;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    // per-frame observation log, filled by tick()
    int          cyc = 0;
    logic [27:0] draws [$];
    int          addr_q [$];
    int          done_cnt, done_cyc, t0, first_draw, tmo_first, unstable;
    logic        prev_busy;
    logic [8:0]  prev_addr;
    logic [27:0] held;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        draws.delete();
        addr_q.delete();
        done_cnt   = 0;
        done_cyc   = -1;
        t0         = -1;
        first_draw = -1;
        tmo_first  = -1;
        unstable   = 0;
        prev_busy  = 1'b0;
        prev_addr  = '0;
        held       = '0;
    endtask

    // advance one cycle and sample every output at the falling edge
    task automatic tick();
        logic [27:0] cur;
        @(negedge clk);
        cyc++;
        cur = {x_pos, y_pos, tile_address};
        if (busy === 1'b1 && t0 < 0) t0 = cyc;
        if (draw === 1'b1) begin
            draws.push_back(cur);
            held = cur;
            if (first_draw < 0) first_draw = cyc;
        end else if (drawer_active === 1'b1 && cur !== held) begin
            unstable++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (timeout_err === 1'b1 && tmo_first < 0) tmo_first = cyc;
        if (busy === 1'b1 && (!prev_busy || map_address != prev_addr))
            addr_q.push_back(int'(map_address));
        prev_busy = busy;
        prev_addr = map_address;
    endtask

    task automatic begin_frame();
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("tmo_clear_on_start", timeout_err, 0);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            tick();
            k++;
        end
        repeat (8) tick();
        chk("done_pulses", done_cnt, 1);
        chk("busy_after_done", busy, 0);
    endtask

    // expected draw list computed straight from the map contents
    task automatic check_model(input string tag);
        logic [27:0] exp_q [$];
        int n;
        for (int i = 0; i < CELLS; i++) begin
            int idx = int'(mem[i]);
            int c = i % COLS;
            int r = i / COLS;
            if (idx < NT && !(SKIP_BLANK && idx == 0))
                exp_q.push_back({8'(c * 8), 8'(r * 8), 12'(idx * 192)});
        end
        chk({tag, "_draw_count"}, draws.size(), exp_q.size());
        n = (draws.size() < exp_q.size()) ? draws.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_draw%0d", tag, i), draws[i], exp_q[i]);
        chk({tag, "_addr_count"}, addr_q.size(), CELLS);
        for (int i = 0; i < addr_q.size() && i < CELLS; i++)
            chk($sformatf("%s_addr%0d", tag, i), addr_q[i], i);
        chk({tag, "_stable"}, unstable, 0);
        $display("frame %s: draws=%0d expected_draws=%0d done_pulses=%0d",
                 tag, draws.size(), exp_q.size(), done_cnt);
    endtask

    initial begin
        int k;
        int n_expect;
        bit found;
        resetn = 1'b0;
        start  = 1'b0;
        for (int i = 0; i < CELLS; i++) mem[i] = 8'd1;
        clear_log();
        repeat (3) tick();

        // reset state
        chk("rst_draw", draw, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_map_address", map_address, 0);
        chk("rst_tile_address", tile_address, 0);
        chk("rst_pos", {x_pos, y_pos}, 0);
        resetn = 1'b1;
        repeat (3) tick();
        chk("idle_busy", busy, 0);

        // all index 1, drawer busy 200 cycles per tile
        dr_dur = 200;
        begin_frame();
        wait_done(80000);
        check_model("all1");
        chk("all1_last_x", x_pos, 152);
        chk("all1_last_y", y_pos, 112);
        chk("all1_last_tile", tile_address, 192);
        chk("all1_tmo", timeout_err, 0);

        // random map, cell 21 forced to index 20
        for (int i = 0; i < CELLS; i++) mem[i] = 8'($urandom_range(0, 30));
        mem[21] = 8'd20;
        dr_dur = int'($urandom_range(1, 4));
        begin_frame();
        wait_done(20000);
        check_model("rand");
        found = 1'b0;
        foreach (draws[i]) if (draws[i] == {8'd8, 8'd8, 12'd3840}) found = 1'b1;
        chk("cell21_draw", found, 1);

        // all index 25: nothing drawn, 3 cycles per cell
        for (int i = 0; i < CELLS; i++) mem[i] = 8'd25;
        begin_frame();
        wait_done(2000);
        check_model("all25");
        chk("all25_done_latency", done_cyc - t0, 900);

        // drawer never acknowledges
        for (int i = 0; i < CELLS; i++) mem[i] = 8'd1;
        dr_never = 1'b1;
        begin_frame();
        wait_done(10000);
        check_model("noack");
        chk("noack_tmo_delay", tmo_first - first_draw, 17);
        chk("noack_tmo_sticky", timeout_err, 1);
        dr_never = 1'b0;

        // all index 0 with a start pulse in the middle of the frame
        for (int i = 0; i < CELLS; i++) mem[i] = 8'd0;
        dr_dur = int'($urandom_range(1, 4));
        begin_frame();
        repeat (300) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(10000);
        check_model("all0");
        n_expect = SKIP_BLANK ? 0 : CELLS;
        chk("all0_draws", draws.size(), n_expect);

        // reset while cell 50 is being issued
        for (int i = 0; i < CELLS; i++) mem[i] = 8'd1;
        dr_dur = 3;
        begin_frame();
        k = 0;
        while (!(draw === 1'b1 && map_address == 9'd50) && k < 5000) begin
            tick();
            k++;
        end
        chk("reached_cell50", (k < 5000), 1);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_draw", draw, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_addr", map_address, 0);
        tick();
        tick();
        resetn = 1'b1;
        repeat (5) tick();
        chk("no_resume_busy", busy, 0);
        $display("frame reset50: abandoned after %0d draws", draws.size());
        begin_frame();
        chk("restart_first_addr", (addr_q.size() > 0) ? addr_q[0] : -1, 0);
        wait_done(20000);
        check_model("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
